la_trigger_unit: RTL and testbench
==================================

Name: la_trigger_unit

Overview:
- Upstream stage of the logic analyzer capture controller; produces the `trig` input that moves the controller from IN_POSITION to FILLING_BUFFER.
- Compares a probe bus against two configurable terms, A and B.
- Combines the terms as OR, AND, or a timed sequence (A, then B within a window).
- Arming is one-shot: after firing, the unit waits for the host to re-arm it through the register file.

Parameters:
- PROBE_WIDTH, 8, width of the probe bus and of both compare arguments (≥1).
- WINDOW_WIDTH, 16, width of the sequence-window counter.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- probe  in  PROBE_WIDTH  signal under observation.
- arm  in  1  one-cycle request; latches config and enters ARMED.
- disarm  in  1  one-cycle request; returns to IDLE.
- op_a, op_b  in  4 each  term operations (encoding below).
- arg_a, arg_b  in  PROBE_WIDTH each  term compare arguments.
- combine  in  2  0 = OR, 1 = AND, 2 = SEQ, 3 = never fire.
- seq_window  in  WINDOW_WIDTH  SEQ window length in cycles; 0 is treated as 1.
- trig  out  1  one-cycle pulse when the trigger condition is met.
- armed  out  1  high in ARMED or SEQ_WAIT.
- fired  out  1  high in FIRED (sticky until arm, disarm or rst).

Behaviour:
- Reset (asynchronous, rst high):
  - state = IDLE; trig, armed, fired = 0.
  - All pipeline registers, latched config and the window counter = 0; prev_valid = 0.
- Config latch: on any cycle with arm high, op_a/op_b/arg_a/arg_b/combine/seq_window are registered. Changes while armed are ignored.
- Ops (all comparisons unsigned):
  - 0 = never true.
  - 1 = RISING (prev < cur); 2 = FALLING (prev > cur); 3 = CHANGING (prev != cur).
  - 4 = GT (cur > arg); 5 = LT; 6 = GEQ; 7 = LEQ; 8 = EQ; 9 = NEQ.
  - 10–15 = never true.
  - For width 1, RISING/FALLING reduce to true edges.
- Pipeline:
  - Edge k: probe_q <= probe; prev_q <= probe_q; prev_valid <= 1 one cycle after the first sample following arm.
  - Edge k+1: hit_a and hit_b are registered from probe_q/prev_q.
  - Edge k+2: trig registered.
  - Fixed latency: a probe value present before edge k yields trig high after edge k+2.
  - Edge ops (1–3) are forced false while prev_valid = 0. arm clears prev_valid, so there are no spurious edges on stale data.
- FSM:
  - IDLE: trig = 0. arm → ARMED.
  - ARMED:
    - OR: hit_a | hit_b → FIRED, trig pulse.
    - AND: hit_a & hit_b → FIRED, trig pulse.
    - SEQ: hit_a → SEQ_WAIT, cnt = max(seq_window, 1). A simultaneous hit_b in this cycle is ignored.
    - combine = 3: stay in ARMED.
  - SEQ_WAIT:
    - hit_b → FIRED, trig pulse.
    - Else if cnt == 1 → ARMED.
    - Else cnt <= cnt − 1.
    - hit_a during SEQ_WAIT does not restart the window.
  - FIRED: trig = 0 after the single pulse cycle. Holds until arm (→ ARMED) or disarm (→ IDLE).
- Priority, highest first: rst > disarm > arm > normal transitions.
  - arm in any state restarts: reload config, clear cnt, prev_valid = 0, state = ARMED.
  - disarm with arm in the same cycle → IDLE.
- trig is exactly one cycle wide per firing and never asserts outside the ARMED/SEQ_WAIT → FIRED transition.
- The window counter saturates logically (it never wraps) because the exit at cnt == 1 precedes any decrement below 1.

Test Plan:
- Reset → trig = armed = fired = 0. Drive probe 0→0xFF with no arm → trig stays 0.
- op_a = EQ, arg_a = 0x5A, combine = OR, arm; probe = 0x5A at edge k:
  - trig high for exactly one cycle after edge k+2.
  - fired = 1, armed = 0.
  - A second 0x5A produces no further pulse.
- op_a = RISING, PROBE_WIDTH = 1, probe held at 1 across arm → no trig. Probe 0→1 → one trig pulse.
- combine = AND, op_a = GT 0x10, op_b = LT 0x20:
  - probe = 0x30 → none.
  - probe = 0x15 → trig.
- combine = SEQ, op_a = EQ 1, op_b = EQ 2, seq_window = 3:
  - Probe 1 then 2 three cycles later → trig.
  - Repeat with 2 four cycles later → no trig, armed = 1.
  - seq_window = 0 with 2 on the next cycle → trig.
- Arm and disarm in the same cycle → IDLE, armed = 0.
- Assert rst mid-SEQ_WAIT → immediate IDLE, all outputs 0, no trig after rst release.

Source files
------------

// File: rtl/la_trigger_unit.sv
// Logic analyzer trigger unit: two compare terms on a probe bus, combined as
// OR / AND / timed sequence, producing a one-shot registered trigger pulse.
module la_trigger_unit #(
    parameter int unsigned PROBE_WIDTH  = 8,
    parameter int unsigned WINDOW_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PROBE_WIDTH-1:0]  probe,
    input  logic                    arm,
    input  logic                    disarm,
    input  logic [3:0]              op_a,
    input  logic [3:0]              op_b,
    input  logic [PROBE_WIDTH-1:0]  arg_a,
    input  logic [PROBE_WIDTH-1:0]  arg_b,
    input  logic [1:0]              combine,
    input  logic [WINDOW_WIDTH-1:0] seq_window,
    output logic                    trig,
    output logic                    armed,
    output logic                    fired
);

    localparam logic [3:0] OP_RISING   = 4'd1;
    localparam logic [3:0] OP_FALLING  = 4'd2;
    localparam logic [3:0] OP_CHANGING = 4'd3;
    localparam logic [3:0] OP_GT       = 4'd4;
    localparam logic [3:0] OP_LT       = 4'd5;
    localparam logic [3:0] OP_GEQ      = 4'd6;
    localparam logic [3:0] OP_LEQ      = 4'd7;
    localparam logic [3:0] OP_EQ       = 4'd8;
    localparam logic [3:0] OP_NEQ      = 4'd9;

    localparam logic [1:0] COMB_OR  = 2'd0;
    localparam logic [1:0] COMB_AND = 2'd1;
    localparam logic [1:0] COMB_SEQ = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMED    = 2'd1,
        S_SEQ_WAIT = 2'd2,
        S_FIRED    = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [WINDOW_WIDTH-1:0] cnt, cnt_nxt;
    logic                    trig_d, armed_d, fired_d;

    logic [PROBE_WIDTH-1:0]  probe_q, prev_q;
    logic                    samp_valid, prev_valid;
    logic                    hit_a, hit_b;

    logic [3:0]              cfg_op_a, cfg_op_b;
    logic [PROBE_WIDTH-1:0]  cfg_arg_a, cfg_arg_b;
    logic [1:0]              cfg_combine;
    logic [WINDOW_WIDTH-1:0] cfg_window;

    // Edge ops are suppressed until both samples postdate the last arm.
    function automatic logic term_hit(input logic [3:0]             op,
                                      input logic [PROBE_WIDTH-1:0] arg,
                                      input logic [PROBE_WIDTH-1:0] cur,
                                      input logic [PROBE_WIDTH-1:0] prv,
                                      input logic                   pv);
        case (op)
            OP_RISING:   return pv && (prv < cur);
            OP_FALLING:  return pv && (prv > cur);
            OP_CHANGING: return pv && (prv != cur);
            OP_GT:       return cur > arg;
            OP_LT:       return cur < arg;
            OP_GEQ:      return cur >= arg;
            OP_LEQ:      return cur <= arg;
            OP_EQ:       return cur == arg;
            OP_NEQ:      return cur != arg;
            default:     return 1'b0;
        endcase
    endfunction

    // Probe sampling, term evaluation and config latch; arm flushes stale hits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            probe_q     <= '0;
            prev_q      <= '0;
            samp_valid  <= 1'b0;
            prev_valid  <= 1'b0;
            hit_a       <= 1'b0;
            hit_b       <= 1'b0;
            cfg_op_a    <= '0;
            cfg_op_b    <= '0;
            cfg_arg_a   <= '0;
            cfg_arg_b   <= '0;
            cfg_combine <= '0;
            cfg_window  <= '0;
        end else begin
            probe_q <= probe;
            prev_q  <= probe_q;
            if (arm) begin
                samp_valid  <= 1'b0;
                prev_valid  <= 1'b0;
                hit_a       <= 1'b0;
                hit_b       <= 1'b0;
                cfg_op_a    <= op_a;
                cfg_op_b    <= op_b;
                cfg_arg_a   <= arg_a;
                cfg_arg_b   <= arg_b;
                cfg_combine <= combine;
                cfg_window  <= seq_window;
            end else begin
                samp_valid <= 1'b1;
                prev_valid <= samp_valid;
                hit_a      <= term_hit(cfg_op_a, cfg_arg_a, probe_q, prev_q, prev_valid);
                hit_b      <= term_hit(cfg_op_b, cfg_arg_b, probe_q, prev_q, prev_valid);
            end
        end
    end

    // State register with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            trig  <= 1'b0;
            armed <= 1'b0;
            fired <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            trig  <= trig_d;
            armed <= armed_d;
            fired <= fired_d;
        end
    end

    // Next-state logic: disarm beats arm beats normal transitions.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (disarm) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else if (arm) begin
            state_nxt = S_ARMED;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_ARMED: begin
                    case (cfg_combine)
                        COMB_OR:  if (hit_a || hit_b) state_nxt = S_FIRED;
                        COMB_AND: if (hit_a && hit_b) state_nxt = S_FIRED;
                        COMB_SEQ: begin
                            if (hit_a) begin
                                state_nxt = S_SEQ_WAIT;
                                cnt_nxt   = (cfg_window == '0) ? WINDOW_WIDTH'(1) : cfg_window;
                            end
                        end
                        default: ;
                    endcase
                end
                S_SEQ_WAIT: begin
                    if (hit_b) begin
                        state_nxt = S_FIRED;
                    end else if (cnt == WINDOW_WIDTH'(1)) begin
                        state_nxt = S_ARMED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - WINDOW_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from the transition being taken.
    always_comb begin
        trig_d  = 1'b0;
        armed_d = 1'b0;
        fired_d = 1'b0;
        if ((state == S_ARMED || state == S_SEQ_WAIT) && state_nxt == S_FIRED)
            trig_d = 1'b1;
        if (state_nxt == S_ARMED || state_nxt == S_SEQ_WAIT)
            armed_d = 1'b1;
        if (state_nxt == S_FIRED)
            fired_d = 1'b1;
    end

endmodule

// File: tb/tb_la_trigger_unit.sv
// Directed self-checking bench for la_trigger_unit (8-bit and 1-bit probe instances).
module tb_la_trigger_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  probe;
    logic        probe1;
    logic        arm, disarm;
    logic [3:0]  op_a, op_b;
    logic [7:0]  arg_a, arg_b;
    logic [1:0]  combine;
    logic [15:0] seq_window;
    logic        trig, armed, fired;
    logic        trig1, armed1, fired1;

    int n_cmp = 0;
    int n_err = 0;
    logic trig_seen, trig1_seen;

    always #5 clk = ~clk;

    la_trigger_unit #(.PROBE_WIDTH(8), .WINDOW_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .probe(probe), .arm(arm), .disarm(disarm),
        .op_a(op_a), .op_b(op_b), .arg_a(arg_a), .arg_b(arg_b),
        .combine(combine), .seq_window(seq_window),
        .trig(trig), .armed(armed), .fired(fired)
    );

    la_trigger_unit #(.PROBE_WIDTH(1), .WINDOW_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .probe(probe1), .arm(arm), .disarm(disarm),
        .op_a(op_a), .op_b(op_b), .arg_a(arg_a[0]), .arg_b(arg_b[0]),
        .combine(combine), .seq_window(seq_window),
        .trig(trig1), .armed(armed1), .fired(fired1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            trig_seen  = trig_seen | trig;
            trig1_seen = trig1_seen | trig1;
        end
    endtask

    task automatic do_arm(input logic [3:0] oa, input logic [7:0] aa,
                          input logic [3:0] ob, input logic [7:0] ab,
                          input logic [1:0] cmb, input logic [15:0] win);
        op_a = oa; arg_a = aa; op_b = ob; arg_b = ab;
        combine = cmb; seq_window = win;
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; probe = '0; probe1 = 1'b0; arm = 1'b0; disarm = 1'b0;
        op_a = '0; op_b = '0; arg_a = '0; arg_b = '0; combine = '0; seq_window = '0;
        trig_seen = 1'b0; trig1_seen = 1'b0;

        // Reset state and unarmed sweep
        tick(2);
        chk("reset_trig", trig, 1'b0);
        chk("reset_armed", armed, 1'b0);
        chk("reset_fired", fired, 1'b0);
        rst = 1'b0;
        trig_seen = 1'b0;
        for (int i = 0; i < 256; i++) begin
            probe = 8'(i);
            tick(1);
        end
        probe = '0;
        tick(3);
        chk("idle_sweep_no_trig", trig_seen, 1'b0);

        // EQ 0x5A, OR; arg change after arm must be ignored
        do_arm(4'd8, 8'h5A, 4'd0, 8'h00, 2'd0, 16'd0);
        arg_a = 8'h00;
        chk("eq_armed", armed, 1'b1);
        chk("eq_not_fired", fired, 1'b0);
        tick(3);
        probe = 8'h5A;
        tick(1);
        probe = 8'h00;
        tick(1);
        chk("eq_k1_no_trig", trig, 1'b0);
        tick(1);
        chk("eq_k2_trig", trig, 1'b1);
        chk("eq_fired", fired, 1'b1);
        chk("eq_disarmed", armed, 1'b0);
        tick(1);
        chk("eq_pulse_one_cycle", trig, 1'b0);
        trig_seen = 1'b0;
        probe = 8'h5A;
        tick(1);
        probe = 8'h00;
        tick(4);
        chk("eq_one_shot", trig_seen, 1'b0);
        chk("eq_fired_sticky", fired, 1'b1);

        // RISING on 1-bit probe held high across arm
        probe1 = 1'b1;
        tick(2);
        trig1_seen = 1'b0;
        do_arm(4'd1, 8'h00, 4'd0, 8'h00, 2'd0, 16'd0);
        tick(5);
        chk("rise_held_no_trig", trig1_seen, 1'b0);
        chk("rise_armed", armed1, 1'b1);
        probe1 = 1'b0;
        tick(1);
        probe1 = 1'b1;
        tick(2);
        chk("rise_k1_no_trig", trig1, 1'b0);
        tick(1);
        chk("rise_k2_trig", trig1, 1'b1);
        tick(1);
        chk("rise_pulse_one_cycle", trig1, 1'b0);
        chk("rise_fired", fired1, 1'b1);

        // AND: GT 0x10 and LT 0x20
        do_arm(4'd4, 8'h10, 4'd5, 8'h20, 2'd1, 16'd0);
        trig_seen = 1'b0;
        probe = 8'h30;
        tick(1);
        probe = 8'h00;
        tick(4);
        chk("and_0x30_no_trig", trig_seen, 1'b0);
        chk("and_still_armed", armed, 1'b1);
        probe = 8'h15;
        tick(1);
        probe = 8'h00;
        tick(1);
        chk("and_k1_no_trig", trig, 1'b0);
        tick(1);
        chk("and_0x15_trig", trig, 1'b1);
        chk("and_fired", fired, 1'b1);

        // SEQ window 3: B three cycles after A fires
        do_arm(4'd8, 8'h01, 4'd8, 8'h02, 2'd2, 16'd3);
        probe = 8'h01;
        tick(1);
        probe = 8'h00;
        tick(2);
        chk("seq_wait_armed", armed, 1'b1);
        probe = 8'h02;
        tick(1);
        probe = 8'h00;
        tick(1);
        chk("seq3_k4_no_trig", trig, 1'b0);
        tick(1);
        chk("seq3_trig", trig, 1'b1);
        chk("seq3_fired", fired, 1'b1);

        // SEQ window 3: B four cycles after A is too late
        do_arm(4'd8, 8'h01, 4'd8, 8'h02, 2'd2, 16'd3);
        trig_seen = 1'b0;
        probe = 8'h01;
        tick(1);
        probe = 8'h00;
        tick(3);
        probe = 8'h02;
        tick(1);
        probe = 8'h00;
        tick(6);
        chk("seq4_no_trig", trig_seen, 1'b0);
        chk("seq4_armed", armed, 1'b1);
        chk("seq4_not_fired", fired, 1'b0);

        // SEQ window 0 behaves as 1
        do_arm(4'd8, 8'h01, 4'd8, 8'h02, 2'd2, 16'd0);
        probe = 8'h01;
        tick(1);
        probe = 8'h02;
        tick(1);
        probe = 8'h00;
        tick(1);
        chk("seq0_k2_no_trig", trig, 1'b0);
        tick(1);
        chk("seq0_trig", trig, 1'b1);

        // Arm and disarm in the same cycle
        arm = 1'b1; disarm = 1'b1;
        tick(1);
        arm = 1'b0; disarm = 1'b0;
        chk("armdis_armed", armed, 1'b0);
        chk("armdis_fired", fired, 1'b0);
        trig_seen = 1'b0;
        probe = 8'h01;
        tick(1);
        probe = 8'h02;
        tick(4);
        chk("armdis_idle_no_trig", trig_seen, 1'b0);
        probe = 8'h00;

        // Reset in SEQ_WAIT
        do_arm(4'd8, 8'h01, 4'd8, 8'h02, 2'd2, 16'd3);
        probe = 8'h01;
        tick(1);
        probe = 8'h00;
        tick(2);
        chk("rstseq_armed_before", armed, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstseq_trig", trig, 1'b0);
        chk("rstseq_armed", armed, 1'b0);
        chk("rstseq_fired", fired, 1'b0);
        tick(1);
        rst = 1'b0;
        trig_seen = 1'b0;
        probe = 8'h02;
        tick(1);
        probe = 8'h00;
        tick(5);
        chk("rstseq_no_trig_after", trig_seen, 1'b0);
        chk("rstseq_idle", armed, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
